apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 DATA_WIDTH, 32, APB data width in bits.
REQ-002 ADDR_WIDTH, 10, APB address width in bits.
REQ-003 BYTES_PER_WORD, DATA_WIDTH/8, strobe width.
REQ-004 TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-005 pclk  input  1  sole clock; all state updates on the rising edge.
REQ-006 preset_n  input  1  reset; asynchronous, active-low.
REQ-007 req_valid  input  1  requester presents a transfer.
REQ-008 req_ready  output  1  block accepts a transfer this cycle.
REQ-009 req_addr  input  ADDR_WIDTH  transfer address.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 req_strb  input  BYTES_PER_WORD  write byte strobes.
REQ-013 req_prot  input  3  protection attributes.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  requester consumes the response.
REQ-016 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-017 rsp_error  output  1  slave error or timeout.
REQ-018 rsp_timeout  output  1  transfer aborted by timeout.
REQ-019 paddr  output  ADDR_WIDTH  APB address.
REQ-020 pprot  output  3  APB protection.
REQ-021 psel  output  1  APB select.
REQ-022 penable  output  1  APB enable.
REQ-023 pwrite  output  1  APB direction.
REQ-024 pwdata  output  DATA_WIDTH  APB write data.
REQ-025 pstrb  output  BYTES_PER_WORD  APB strobes.
REQ-026 pready  input  1  slave completion.
REQ-027 prdata  input  DATA_WIDTH  slave read data.
REQ-028 pslverr  input  1  slave error.

Function
REQ-029 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-030 req_ready is 1 only in IDLE and is combinational from state; req_valid&&req_ready registers req_addr, req_prot, req_write, req_wdata into paddr, pprot, pwrite, pwdata, registers req_strb into pstrb for writes and all-zero for reads, and moves to SETUP.
REQ-031 SETUP lasts exactly one cycle: psel=1, penable=0; then ACCESS.
REQ-032 ACCESS: psel=1, penable=1; paddr, pprot, pwrite, pwdata, pstrb stay stable from SETUP until the transfer ends.
REQ-033 In ACCESS with pready=1: capture prdata into rsp_rdata for reads only (0 for writes), capture pslverr into rsp_error, set rsp_timeout=0, and go to RESP; psel and penable are 0 on the next cycle.
REQ-034 Timeout counter: cleared on entry to ACCESS, incremented each ACCESS cycle with pready=0; when TIMEOUT_CYCLES!=0, count==TIMEOUT_CYCLES-1 and pready=0, go to RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
REQ-035 pready=1 in the terminal timeout cycle completes the transfer normally (no timeout).
REQ-036 RESP: rsp_valid=1, psel=0, penable=0; rsp_rdata, rsp_error, rsp_timeout are held stable until rsp_valid&&rsp_ready, then IDLE.
REQ-037 pready, prdata and pslverr are ignored outside ACCESS.
REQ-038 Minimum spacing between accepted requests is 4 cycles (IDLE, SETUP, ACCESS, RESP), with zero wait states and rsp_ready=1.
REQ-039 paddr, pprot, pwrite, pwdata, pstrb hold their last values in IDLE and RESP.

Reset
REQ-040 preset_n=0 asynchronously forces state IDLE, timeout counter 0, and every output register (paddr, pprot, psel, penable, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_error, rsp_timeout) to 0; req_ready is therefore 1.
REQ-041 Reset mid-transfer drops psel and penable immediately and discards the pending response; the first acceptance occurs on the first rising edge after preset_n=1.

Verification
REQ-042 Write 0x004/0xDEADBEEF/strb 0xF, pready=1 on the first ACCESS cycle -> psel=1 penable=0 for 1 cycle, penable=1 for 1 cycle, then rsp_valid=1, rsp_error=0, rsp_rdata=0.
REQ-043 Read 0x3FC, pready after 3 wait cycles with prdata=0x12345678 -> penable=1 for 4 cycles, pstrb=0, rsp_rdata=0x12345678.
REQ-044 pready=1 with pslverr=1 -> rsp_error=1, rsp_timeout=0.
REQ-045 TIMEOUT_CYCLES=16, pready held 0 -> psel=0 after 16 ACCESS cycles, rsp_error=1, rsp_timeout=1; repeat with pready=1 in cycle 16 -> normal completion.
REQ-046 rsp_ready=0 for 5 cycles with req_valid=1 -> response stable, req_ready=0, no SETUP; then back-to-back requests accepted every 4 cycles.
REQ-047 preset_n=0 during ACCESS -> psel=penable=rsp_valid=0 before the next edge; req_ready=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: turns a valid/ready request into one APB transfer and returns a held response.
// A transfer that waits too long in ACCESS is aborted with a timeout error.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      req_write,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [BYTES_PER_WORD-1:0] req_strb,
  input  logic [2:0]                req_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_error,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [2:0]                pprot,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [BYTES_PER_WORD-1:0] pstrb,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
  logic [2:0]                pprot_q, pprot_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
  logic [BYTES_PER_WORD-1:0] pstrb_q, pstrb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_error_q, rsp_error_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic                      timeout_hit;
  assign req_ready   = (state_q == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !pready;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d  = SETUP;
        paddr_d  = req_addr;
        pprot_d  = req_prot;
        pwrite_d = req_write;
        pwdata_d = req_wdata;
        pstrb_d  = req_write ? req_strb : '0;
        psel_d   = 1'b1;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: if (pready || timeout_hit) begin
        state_d       = RESP;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = (pready && !pwrite_q) ? prdata : '0;
        rsp_error_d   = pready ? pslverr : 1'b1;
        rsp_timeout_d = !pready;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign paddr       = paddr_q;
  assign pprot       = pprot_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed table plus random transfers against a cycle-count/response model,
// and hand sequences for back-pressure, back-to-back spacing and mid-transfer reset.
module tb_apb_master;
  localparam int TO = 16;
  logic        pclk, preset_n;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [9:0]  paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;
  int ncmp = 0, nerr = 0, cyc = 0, setup_cyc = 0, prev_setup = 0;

  apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial begin
    pclk = 0;
    forever #5 pclk = ~pclk;
  end
  always @(posedge pclk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    end
  endtask

  // Outcome of one transfer derived directly from wait count and slave answer.
  function automatic vec_t model(input vec_t v);
    logic t;
    t = (TO != 0) && (v.waits >= TO);
    v.exp_to    = t;
    v.exp_err   = t || v.slverr;
    v.exp_rdata = (t || v.wr) ? 32'h0 : v.rdata;
    v.exp_acc   = t ? TO : v.waits + 1;
    return v;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input logic [2:0] p, input int w,
                              input logic [31:0] rd, input logic se, input int h,
                              input logic [31:0] er, input logic ee, input logic et, input int ea);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.strb = s; v.prot = p; v.waits = w;
    v.rdata = rd; v.slverr = se; v.hold = h;
    v.exp_rdata = er; v.exp_err = ee; v.exp_to = et; v.exp_acc = ea;
    return v;
  endfunction

  // Starts and ends at a falling edge with the DUT idle.
  task automatic run(input vec_t v);
    int acc;
    logic [3:0] es;
    es = v.wr ? v.strb : 4'h0;
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1; req_addr = v.addr; req_write = v.wr; req_wdata = v.wdata;
    req_strb = v.strb; req_prot = v.prot;
    pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    @(negedge pclk);
    prev_setup = setup_cyc; setup_cyc = cyc;
    req_valid = 0; req_addr = 10'($urandom); req_wdata = $urandom; req_strb = 4'($urandom);
    req_prot = 3'($urandom); req_write = ~v.wr;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", pwrite, v.wr);
    chk("setup_pwdata", pwdata, v.wdata);
    chk("setup_pstrb", pstrb, es);
    chk("setup_pprot", pprot, v.prot);
    chk("setup_req_ready", req_ready, 0);
    pready = 1; pslverr = 1; prdata = $urandom;
    acc = 0;
    while (acc < 100) begin
      @(negedge pclk);
      if (!(psel && penable)) break;
      acc++;
      chk("access_paddr", paddr, v.addr);
      chk("access_pstrb", pstrb, es);
      chk("access_pwdata", pwdata, v.wdata);
      pready = (acc == v.waits + 1);
      prdata = v.rdata;
      pslverr = v.slverr;
    end
    pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    chk("access_cycles", acc, v.exp_acc);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_rdata", rsp_rdata, v.exp_rdata);
    chk("resp_error", rsp_error, v.exp_err);
    chk("resp_timeout", rsp_timeout, v.exp_to);
    chk("resp_paddr_hold", paddr, v.addr);
    if (v.hold > 0) begin
      rsp_ready = 0; req_valid = 1;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge pclk);
        pready = 1'($urandom); prdata = $urandom;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, v.exp_rdata);
        chk("hold_error", rsp_error, v.exp_err);
        chk("hold_timeout", rsp_timeout, v.exp_to);
        chk("hold_req_ready", req_ready, 0);
        chk("hold_no_setup", psel, 0);
      end
      rsp_ready = 1; req_valid = 0;
    end
    @(negedge pclk);
    chk("post_resp_valid", rsp_valid, 0);
  endtask

  vec_t dir[7];
  vec_t rv;

  initial begin
    preset_n = 0; req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0;
    req_strb = 0; req_prot = 0; rsp_ready = 1; pready = 0; prdata = 0; pslverr = 0;
    dir[0] = mk(1, 10'h004, 32'hDEADBEEF, 4'hF, 3'd0, 0,  32'hA5A5A5A5, 0, 0, 32'h0, 0, 0, 1);
    dir[1] = mk(0, 10'h3FC, 32'h0,        4'hF, 3'd2, 3,  32'h12345678, 0, 0, 32'h12345678, 0, 0, 4);
    dir[2] = mk(0, 10'h010, 32'h0,        4'h0, 3'd1, 0,  32'hCAFEF00D, 1, 0, 32'hCAFEF00D, 1, 0, 1);
    dir[3] = mk(0, 10'h020, 32'h0,        4'h0, 3'd0, 99, 32'h11111111, 0, 0, 32'h0, 1, 1, 16);
    dir[4] = mk(0, 10'h024, 32'h0,        4'h0, 3'd7, 15, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 0, 16);
    dir[5] = mk(1, 10'h100, 32'h01020304, 4'h5, 3'd3, 2,  32'h99999999, 1, 5, 32'h0, 1, 0, 3);
    dir[6] = mk(1, 10'h2A8, 32'h55AA55AA, 4'h3, 3'd4, 99, 32'h77777777, 0, 2, 32'h0, 1, 1, 16);
    repeat (2) @(negedge pclk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_error", rsp_error, 0);
    preset_n = 1;
    for (int i = 0; i < 7; i++) run(dir[i]);
    for (int i = 0; i < 3; i++) begin
      run(mk(1, 10'(i * 4), 32'(i), 4'hF, 3'd0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1));
      if (i > 0) chk("b2b_spacing", setup_cyc - prev_setup, 4);
    end
    for (int i = 0; i < 40; i++) begin
      rv.wr = 1'($urandom); rv.addr = 10'($urandom); rv.wdata = $urandom;
      rv.strb = 4'($urandom); rv.prot = 3'($urandom);
      rv.waits = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 30) : $urandom_range(0, 6);
      rv.rdata = $urandom; rv.slverr = ($urandom_range(0, 3) == 0); rv.hold = $urandom_range(0, 3);
      run(model(rv));
    end
    req_valid = 1; req_addr = 10'h155; req_write = 0; req_wdata = 0; req_strb = 0; req_prot = 0;
    @(negedge pclk);
    req_valid = 0; pready = 0;
    repeat (3) @(negedge pclk);
    chk("pre_rst_access", psel && penable, 1);
    preset_n = 0;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_paddr", paddr, 0);
    @(negedge pclk);
    preset_n = 1;
    run(mk(0, 10'h3FC, 32'h0, 4'h0, 3'd5, 1, 32'h87654321, 0, 0, 32'h87654321, 0, 0, 2));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
